vga_sync_gen: RTL and testbench

- Raster timing generator that drives the pixel-side interface consumed by the snake renderer: pix_x, pix_y, video_on, plus hsync/vsync to the VGA connector.
- Derives a pixel-rate clock enable from the system clock and runs horizontal and vertical counters for 640x480@60.
- Emits a one-cycle frame_start pulse for frame-synchronous logic.
- Sits at the top level beside the renderer. Renderer rgb is qualified by video_on from this block.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/pix_tick_gen.sv | 24 ++
 rtl/vga_sync_gen.sv | 82 ++++++++
 tb/tb_vga_sync_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster constants and renderer colour palette
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int H_TOTAL = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // 4:4:4 rgb shared with the snake renderer
    localparam logic [11:0] RGB_BLANK  = 12'h000;
    localparam logic [11:0] RGB_BORDER = 12'h888;
    localparam logic [11:0] RGB_SNAKE  = 12'h0f0;
    localparam logic [11:0] RGB_APPLE  = 12'hf00;

endpackage

// File: rtl/pix_tick_gen.sv
// rtl/pix_tick_gen.sv - system-clock prescaler producing a one-clk pixel enable
module pix_tick_gen #(
    parameter int PIX_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_tick
);

    localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

    logic [3:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= 4'd0;
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= (div_cnt == DIV_LAST);
            div_cnt  <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - free-running raster counters with registered sync and video decode
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   PIX_DIV  = 4,
    parameter int   H_VIS    = H_VIS_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_VIS    = V_VIS_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               pix_tick,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(HT - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(VT - 1);
    localparam logic [COORD_W-1:0] H_VIS_L  = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] V_VIS_L  = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VIS + V_FP + V_SYNC);

    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;

    pix_tick_gen #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_tick (pix_tick)
    );

    always_comb begin
        next_x = pix_x + ONE;
        next_y = pix_y;
        if (pix_x == H_LAST) begin
            next_x = '0;
            next_y = (pix_y == V_LAST) ? '0 : pix_y + ONE;
        end
    end

    // Decodes use next_x/next_y so they land on the same edge as the coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x       <= '0;
            pix_y       <= '0;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_tick) begin
                pix_x       <= next_x;
                pix_y       <= next_y;
                video_on    <= (next_x < H_VIS_L) && (next_y < V_VIS_L);
                hsync       <= (next_x >= HS_START && next_x < HS_END) ? SYNC_POL : ~SYNC_POL;
                vsync       <= (next_y >= VS_START && next_y < VS_END) ? SYNC_POL : ~SYNC_POL;
                frame_start <= (next_x == '0) && (next_y == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen on a shrunken raster
module tb_vga_sync_gen;

    localparam int HV = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VV = 6,  VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VT = VV + VFP + VS + VBP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_tick, a_von, a_hs, a_vs, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_von, b_hs, b_vs, b_fs;
    logic [9:0] b_x, b_y;

    vga_sync_gen #(
        .PIX_DIV(4), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_tick(a_tick), .pix_x(a_x), .pix_y(a_y),
        .video_on(a_von), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
    );

    vga_sync_gen #(
        .PIX_DIV(1), .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_tick(b_tick), .pix_x(b_x), .pix_y(b_y),
        .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
    );

    int n = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: actual %0d required %0d", name, n, act, exp);
        end
    endtask

    // Reference: pixel index p = number of pixel periods completed since reset release.
    task automatic check_model(input string tag, input int d, input bit pol,
                               input logic tick, input logic [9:0] x, input logic [9:0] y,
                               input logic von, input logic hs, input logic vs, input logic fs,
                               input int nn);
        int p, ex, ey;
        bit e_tick, e_fs, e_von, e_hs, e_vs;
        p      = (nn < 1) ? 0 : (nn - 1) / d;
        ex     = p % HT;
        ey     = (p / HT) % VT;
        e_tick = (nn >= d) && (nn % d == 0);
        e_fs   = (p > 0) && (p % (HT * VT) == 0) && ((nn - 1) % d == 0);
        e_von  = (p > 0) && (ex < HV) && (ey < VV);
        e_hs   = (ex >= HV + HFP && ex < HV + HFP + HS) ? pol : !pol;
        e_vs   = (ey >= VV + VFP && ey < VV + VFP + VS) ? pol : !pol;
        cmp({tag, ".pix_tick"},    tick, e_tick);
        cmp({tag, ".pix_x"},       x,    ex);
        cmp({tag, ".pix_y"},       y,    ey);
        cmp({tag, ".video_on"},    von,  e_von);
        cmp({tag, ".hsync"},       hs,   e_hs);
        cmp({tag, ".vsync"},       vs,   e_vs);
        cmp({tag, ".frame_start"}, fs,   e_fs);
    endtask

    always @(negedge clk) begin
        check_model("a", 4, 1'b0, a_tick, a_x, a_y, a_von, a_hs, a_vs, a_fs, n);
        check_model("b", 1, 1'b1, b_tick, b_x, b_y, b_von, b_hs, b_vs, b_fs, n);
    end

    bit win_en = 1'b1;
    int a_hs_cnt = 0, a_vs_cnt = 0, a_von_cnt = 0, a_fs_cnt = 0;
    int b_hs_cnt = 0, b_vs_cnt = 0, b_von_cnt = 0, b_fs_cnt = 0;
    always @(negedge clk) begin
        if (win_en && rst_n) begin
            if (n >= 5 && n <= 4 * HT * VT + 4) begin
                a_hs_cnt  += int'(a_hs == 1'b0);
                a_vs_cnt  += int'(a_vs == 1'b0);
                a_von_cnt += int'(a_von);
                a_fs_cnt  += int'(a_fs);
            end
            if (n >= 2 && n <= HT * VT + 1) begin
                b_hs_cnt  += int'(b_hs == 1'b1);
                b_vs_cnt  += int'(b_vs == 1'b1);
                b_von_cnt += int'(b_von);
                b_fs_cnt  += int'(b_fs);
            end
        end
    end

    typedef struct {
        int n; int x; int y;
        bit von; bit hs; bit vs; bit tick; bit fs;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #900000;
        $display("FAIL watchdog expired at edge %0d", n);
        $fatal(1);
    end

    initial begin
        int guard;
        tbl[0]  = '{0,    0,  0, 0, 1, 1, 0, 0};
        tbl[1]  = '{3,    0,  0, 0, 1, 1, 0, 0};
        tbl[2]  = '{4,    0,  0, 0, 1, 1, 1, 0};
        tbl[3]  = '{5,    1,  0, 1, 1, 1, 0, 0};
        tbl[4]  = '{8,    1,  0, 1, 1, 1, 1, 0};
        tbl[5]  = '{9,    2,  0, 1, 1, 1, 0, 0};
        tbl[6]  = '{65,   16, 0, 0, 1, 1, 0, 0};
        tbl[7]  = '{73,   18, 0, 0, 0, 1, 0, 0};
        tbl[8]  = '{85,   21, 0, 0, 0, 1, 0, 0};
        tbl[9]  = '{89,   22, 0, 0, 1, 1, 0, 0};
        tbl[10] = '{101,  0,  1, 1, 1, 1, 0, 0};
        tbl[11] = '{601,  0,  6, 0, 1, 1, 0, 0};
        tbl[12] = '{701,  0,  7, 0, 1, 0, 0, 0};
        tbl[13] = '{897,  24, 8, 0, 1, 0, 0, 0};
        tbl[14] = '{901,  0,  9, 0, 1, 1, 0, 0};
        tbl[15] = '{1000, 24, 9, 0, 1, 1, 1, 0};
        tbl[16] = '{1001, 0,  0, 1, 1, 1, 0, 1};
        tbl[17] = '{1002, 0,  0, 1, 1, 1, 0, 0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            guard = 0;
            while (n < tbl[i].n && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
            cmp("tbl.edge",        n,        tbl[i].n);
            cmp("tbl.pix_x",       a_x,      tbl[i].x);
            cmp("tbl.pix_y",       a_y,      tbl[i].y);
            cmp("tbl.video_on",    a_von,    tbl[i].von);
            cmp("tbl.hsync",       a_hs,     tbl[i].hs);
            cmp("tbl.vsync",       a_vs,     tbl[i].vs);
            cmp("tbl.pix_tick",    a_tick,   tbl[i].tick);
            cmp("tbl.frame_start", a_fs,     tbl[i].fs);
        end

        guard = 0;
        while (n < 1010 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        win_en = 1'b0;
        cmp("a.hsync_clks_per_frame",  a_hs_cnt,  4 * HS * VT);
        cmp("a.vsync_clks_per_frame",  a_vs_cnt,  4 * VS * HT);
        cmp("a.video_clks_per_frame",  a_von_cnt, 4 * HV * VV);
        cmp("a.frame_starts",          a_fs_cnt,  1);
        cmp("b.hsync_clks_per_frame",  b_hs_cnt,  HS * VT);
        cmp("b.vsync_clks_per_frame",  b_vs_cnt,  VS * HT);
        cmp("b.video_clks_per_frame",  b_von_cnt, HV * VV);
        cmp("b.frame_starts",          b_fs_cnt,  1);

        // Asynchronous resets dropped at random points in the frame.
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(200, 2500)) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check_model("a.async_rst", 4, 1'b0, a_tick, a_x, a_y, a_von, a_hs, a_vs, a_fs, 0);
            check_model("b.async_rst", 1, 1'b1, b_tick, b_x, b_y, b_von, b_hs, b_vs, b_fs, 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #1 rst_n = 1'b1;
        end

        repeat (1100) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
